// File: rtl/rf_wport_sched.sv
// Register-file write-port scheduler: pipeline writeback has priority, MDU results wait in a
// FIFO, and a scoreboard tracks registers with an outstanding MDU write.
module rf_wport_sched #(
  parameter int unsigned DEPTH  = 2,
  parameter int unsigned STARVE = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        wb_we,
  input  logic [4:0]  wb_rd,
  input  logic [31:0] wb_data,
  input  logic        mdu_issue,
  input  logic [4:0]  mdu_issue_rd,
  input  logic        mdu_valid,
  input  logic [4:0]  mdu_rd,
  input  logic [31:0] mdu_data,
  output logic        mdu_ready,
  input  logic [4:0]  q_rs1,
  input  logic [4:0]  q_rs2,
  output logic        rs1_busy,
  output logic        rs2_busy,
  output logic        stall_req,
  output logic        RFWr,
  output logic [4:0]  A3,
  output logic [31:0] WD
);

  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = (STARVE > 0) ? $clog2(STARVE + 1) : 1;
  localparam logic [PW:0]   Full      = (PW + 1)'(DEPTH);
  localparam logic [CW-1:0] StarveMax = CW'(STARVE);

  logic [4:0]    fifo_rd_q   [DEPTH];
  logic [31:0]   fifo_data_q [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW:0]   count_q, count_d;
  logic [31:0]   pending_q, pending_d;
  logic [CW-1:0] starve_q, starve_d;
  logic          stall_q, stall_d;

  logic          wb_wr;
  logic          empty;
  logic          push;
  logic          drain;
  logic [4:0]    head_rd;
  logic [31:0]   head_data;

  assign wb_wr     = wb_we && (wb_rd != 5'd0);
  assign empty     = (count_q == '0);
  assign mdu_ready = (count_q != Full);
  assign head_rd   = fifo_rd_q[rd_ptr_q];
  assign head_data = fifo_data_q[rd_ptr_q];

  // rd=0 results complete the handshake but never occupy a slot.
  assign push  = mdu_valid && mdu_ready && (mdu_rd != 5'd0);
  assign drain = !empty && !wb_wr;

  always_comb begin
    RFWr = 1'b0;
    A3   = 5'd0;
    WD   = 32'd0;
    if (wb_wr) begin
      RFWr = 1'b1;
      A3   = wb_rd;
      WD   = wb_data;
    end else if (!empty) begin
      RFWr = 1'b1;
      A3   = head_rd;
      WD   = head_data;
    end
    if (rst) begin
      RFWr = 1'b0;
    end
  end

  assign rs1_busy  = pending_q[q_rs1];
  assign rs2_busy  = pending_q[q_rs2];
  assign stall_req = stall_q;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) begin
      wr_ptr_d = wr_ptr_q + PW'(1);
    end
    if (drain) begin
      rd_ptr_d = rd_ptr_q + PW'(1);
    end
    if (push && !drain) begin
      count_d = count_q + (PW + 1)'(1);
    end else if (!push && drain) begin
      count_d = count_q - (PW + 1)'(1);
    end
  end

  // Clear before set so a same-cycle issue to the draining register keeps it pending.
  always_comb begin
    pending_d = pending_q;
    if (drain) begin
      pending_d[head_rd] = 1'b0;
    end
    if (mdu_issue && (mdu_issue_rd != 5'd0)) begin
      pending_d[mdu_issue_rd] = 1'b1;
    end
    pending_d[0] = 1'b0;
  end

  always_comb begin
    starve_d = starve_q;
    stall_d  = stall_q;
    if (drain || empty) begin
      starve_d = '0;
    end else if (starve_q != StarveMax) begin
      starve_d = starve_q + CW'(1);
    end
    if (drain) begin
      stall_d = 1'b0;
    end else if (starve_q == StarveMax) begin
      stall_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      pending_q <= '0;
      starve_q  <= '0;
      stall_q   <= 1'b0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      pending_q <= pending_d;
      starve_q  <= starve_d;
      stall_q   <= stall_d;
    end
  end

  // Payload storage needs no reset; occupancy alone decides validity.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_rd_q[wr_ptr_q]   <= mdu_rd;
      fifo_data_q[wr_ptr_q] <= mdu_data;
    end
  end

endmodule

// File: tb/tb_rf_wport_sched.sv
// Randomized bench for rf_wport_sched, checked every cycle against a queue-based model,
// plus directed scenarios for priority, backpressure, starvation, scoreboard and reset.
module tb_rf_wport_sched;

  localparam int unsigned DEPTH  = 2;
  localparam int unsigned STARVE = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        wb_we = 1'b0;
  logic [4:0]  wb_rd = '0;
  logic [31:0] wb_data = '0;
  logic        mdu_issue = 1'b0;
  logic [4:0]  mdu_issue_rd = '0;
  logic        mdu_valid = 1'b0;
  logic [4:0]  mdu_rd = '0;
  logic [31:0] mdu_data = '0;
  logic        mdu_ready;
  logic [4:0]  q_rs1 = '0;
  logic [4:0]  q_rs2 = '0;
  logic        rs1_busy, rs2_busy, stall_req, RFWr;
  logic [4:0]  A3;
  logic [31:0] WD;

  rf_wport_sched #(.DEPTH(DEPTH), .STARVE(STARVE)) dut (
    .clk(clk), .rst(rst), .wb_we(wb_we), .wb_rd(wb_rd), .wb_data(wb_data),
    .mdu_issue(mdu_issue), .mdu_issue_rd(mdu_issue_rd), .mdu_valid(mdu_valid),
    .mdu_rd(mdu_rd), .mdu_data(mdu_data), .mdu_ready(mdu_ready), .q_rs1(q_rs1),
    .q_rs2(q_rs2), .rs1_busy(rs1_busy), .rs2_busy(rs2_busy), .stall_req(stall_req),
    .RFWr(RFWr), .A3(A3), .WD(WD)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  typedef struct packed {
    logic [4:0]  rd;
    logic [31:0] data;
  } res_t;

  res_t        mq[$];
  logic [31:0] m_pend;
  int          m_starve;
  logic        m_stall;
  logic        m_last_ready;

  logic        o_ready, o_rfwr, o_b1, o_b2, o_stall;
  logic [4:0]  o_a3;
  logic [31:0] o_wd;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    m_pend       = '0;
    m_starve     = 0;
    m_stall      = 1'b0;
    m_last_ready = 1'b1;
  endtask

  // One clock cycle: drive inputs, compare every output against the model, advance the model.
  task automatic step(input logic we, input logic [4:0] wrd, input logic [31:0] wdat,
                      input logic iss, input logic [4:0] irs, input logic mv,
                      input logic [4:0] mrd, input logic [31:0] mdat,
                      input logic [4:0] r1, input logic [4:0] r2);
    logic        wbw, exp_ready, exp_rfwr, drain;
    logic [4:0]  exp_a3;
    logic [31:0] exp_wd;
    int          size0;
    @(negedge clk);
    wb_we = we; wb_rd = wrd; wb_data = wdat;
    mdu_issue = iss; mdu_issue_rd = irs;
    mdu_valid = mv; mdu_rd = mrd; mdu_data = mdat;
    q_rs1 = r1; q_rs2 = r2;
    #1;
    o_ready = mdu_ready; o_rfwr = RFWr; o_a3 = A3; o_wd = WD;
    o_b1 = rs1_busy; o_b2 = rs2_busy; o_stall = stall_req;

    size0     = mq.size();
    wbw       = we && (wrd != 5'd0);
    exp_ready = (size0 < DEPTH);
    if (wbw) begin
      exp_rfwr = 1'b1; exp_a3 = wrd; exp_wd = wdat;
    end else if (size0 > 0) begin
      exp_rfwr = 1'b1; exp_a3 = mq[0].rd; exp_wd = mq[0].data;
    end else begin
      exp_rfwr = 1'b0; exp_a3 = '0; exp_wd = '0;
    end
    check_eq("mdu_ready", o_ready, exp_ready);
    check_eq("RFWr", o_rfwr, exp_rfwr);
    check_eq("A3", o_a3, exp_a3);
    check_eq("WD", o_wd, exp_wd);
    check_eq("rs1_busy", o_b1, (r1 != 0) && m_pend[r1]);
    check_eq("rs2_busy", o_b2, (r2 != 0) && m_pend[r2]);
    check_eq("stall_req", o_stall, m_stall);

    drain = !wbw && (size0 > 0);
    if (drain) m_stall = 1'b0;
    else if (m_starve == STARVE) m_stall = 1'b1;
    if (drain || size0 == 0) m_starve = 0;
    else if (m_starve < STARVE) m_starve++;
    if (drain) begin
      m_pend[mq[0].rd] = 1'b0;
      void'(mq.pop_front());
    end
    if (mv && exp_ready && mrd != 5'd0) mq.push_back('{rd: mrd, data: mdat});
    if (iss && irs != 5'd0) m_pend[irs] = 1'b1;
    m_last_ready = exp_ready;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  logic        h_mv;
  logic [4:0]  h_rd, h_irs;
  logic [31:0] h_data;
  logic        h_we, h_iss;

  initial begin
    model_reset();
    #1;
    check_eq("reset_ready", mdu_ready, 1);
    check_eq("reset_rfwr", RFWr, 0);
    check_eq("reset_a3", A3, 0);
    check_eq("reset_wd", WD, 0);
    check_eq("reset_stall", stall_req, 0);
    check_eq("reset_busy", rs1_busy | rs2_busy, 0);
    #11 rst = 1'b0;

    // Priority: wb wins, buffered MDU result follows a cycle later.
    step(0, 0, 0, 1, 7, 0, 0, 0, 7, 0);
    step(1, 3, 32'hAAAA, 0, 0, 1, 7, 32'h1234, 7, 0);
    check_eq("prio_a3", o_a3, 3);
    check_eq("prio_wd", o_wd, 32'hAAAA);
    step(0, 0, 0, 0, 0, 0, 0, 0, 7, 0);
    check_eq("prio_mdu_a3", o_a3, 7);
    check_eq("prio_mdu_wd", o_wd, 32'h1234);
    check_eq("prio_busy_drain", o_b1, 1);
    step(0, 0, 0, 0, 0, 0, 0, 0, 7, 0);
    check_eq("prio_busy_after", o_b1, 0);

    // Backpressure with DEPTH=2.
    step(1, 1, 32'h11, 0, 0, 1, 10, 32'hA0, 0, 0);
    step(1, 1, 32'h12, 0, 0, 1, 11, 32'hA1, 0, 0);
    step(1, 1, 32'h13, 0, 0, 1, 12, 32'hA2, 0, 0);
    check_eq("full_ready", o_ready, 0);
    step(0, 0, 0, 0, 0, 1, 12, 32'hA2, 0, 0);
    check_eq("full_drain0_a3", o_a3, 10);
    check_eq("full_ready_drain", o_ready, 0);
    step(0, 0, 0, 0, 0, 1, 12, 32'hA2, 0, 0);
    check_eq("full_drain1_a3", o_a3, 11);
    check_eq("full_ready_back", o_ready, 1);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    check_eq("full_drain2_a3", o_a3, 12);
    idle(1);

    // Starvation: one entry blocked by continuous wb writes.
    step(0, 0, 0, 0, 0, 1, 13, 32'hBEEF, 0, 0);
    for (int i = 1; i <= 6; i++) begin
      step(1, 2, i, 0, 0, 0, 0, 0, 0, 0);
      check_eq("starve_stall", o_stall, (i == 6));
    end
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    check_eq("starve_drain_a3", o_a3, 13);
    check_eq("starve_stall_hold", o_stall, 1);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    check_eq("starve_stall_clear", o_stall, 0);

    // Scoreboard: set-wins collision and rd=0 result.
    step(0, 0, 0, 1, 9, 0, 0, 0, 9, 0);
    step(0, 0, 0, 0, 0, 1, 9, 32'h99, 9, 0);
    check_eq("sb_busy_set", o_b1, 1);
    step(0, 0, 0, 1, 9, 0, 0, 0, 9, 0);
    check_eq("sb_drain_a3", o_a3, 9);
    step(0, 0, 0, 0, 0, 1, 0, 32'h55, 9, 0);
    check_eq("sb_set_wins", o_b1, 1);
    check_eq("sb_rs2_zero", o_b2, 0);
    check_eq("sb_rd0_ready", o_ready, 1);
    step(0, 0, 0, 0, 0, 0, 0, 0, 9, 0);
    check_eq("sb_rd0_nowrite", o_rfwr, 0);
    step(0, 0, 0, 0, 0, 1, 9, 32'h98, 0, 0);
    idle(2);

    // Randomized traffic obeying the MDU hold rule and the hazard unit's stall response.
    h_mv = 1'b0; h_rd = '0; h_data = '0;
    for (int n = 0; n < 1500; n++) begin
      if (!(h_mv && !m_last_ready)) begin
        h_mv   = ($urandom_range(0, 2) != 0);
        h_rd   = 5'($urandom_range(0, 31));
        h_data = $urandom;
      end
      h_irs = 5'($urandom_range(1, 31));
      h_iss = ($urandom_range(0, 3) == 0) && !m_pend[h_irs];
      h_we  = m_stall ? 1'b0 : ($urandom_range(0, 9) < 6);
      step(h_we, 5'($urandom_range(0, 31)), $urandom, h_iss, h_irs, h_mv, h_rd, h_data,
           5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)));
    end
    idle(4);

    // Reset mid-stream with two entries buffered and x5 pending.
    step(1, 4, 32'h44, 1, 5, 1, 20, 32'hC0, 0, 0);
    step(1, 4, 32'h45, 0, 0, 1, 21, 32'hC1, 5, 0);
    step(1, 4, 32'h46, 0, 0, 0, 0, 0, 5, 0);
    check_eq("rst_pre_busy", o_b1, 1);
    check_eq("rst_pre_full", o_ready, 0);
    @(negedge clk);
    wb_we = 1'b1; wb_rd = 5'd4; mdu_valid = 1'b0; q_rs1 = 5'd5;
    #1 rst = 1'b1;
    #1;
    check_eq("rst_mid_ready", mdu_ready, 1);
    check_eq("rst_mid_busy", rs1_busy, 0);
    check_eq("rst_mid_rfwr", RFWr, 0);
    model_reset();
    wb_we = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    idle(4);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/rf_wport_sched.md
# rf_wport_sched

Write-port scheduler and pending-register scoreboard for the 32x32 register file (RF) in the pipelined core. It shares the RF's single write port between two sources. The in-order pipeline writeback stage has fixed highest priority. Results from the multi-cycle mul/div unit (MDU) are accepted through a valid/ready handshake and buffered in a small FIFO until a free write slot appears. The block also tracks which registers have an outstanding MDU result, so the hazard unit can stall dependent instructions.

## Interface
Parameters:
- DEPTH, 2, MDU result FIFO entries (power of two, >=2)
- STARVE, 4, cycles the FIFO head may wait before stall_req asserts (>=1)

Ports:
- clk  in  1  clock; all state updates on posedge
- rst  in  1  reset, asynchronous, active-high
- wb_we  in  1  pipeline writeback valid
- wb_rd  in  5  pipeline destination register
- wb_data  in  32  pipeline writeback data
- mdu_issue  in  1  MDU op issued this cycle
- mdu_issue_rd  in  5  destination of the issued MDU op
- mdu_valid  in  1  MDU result valid
- mdu_rd  in  5  MDU result destination
- mdu_data  in  32  MDU result data
- mdu_ready  out  1  FIFO can accept a result (= !full)
- q_rs1, q_rs2  in  5  source registers queried by the hazard unit
- rs1_busy, rs2_busy  out  1  queried register has a pending MDU write
- stall_req  out  1  request to the hazard unit for a writeback bubble
- RFWr  out  1  RF write enable
- A3  out  5  RF write address
- WD  out  32  RF write data

## Operation
- Write-port select is combinational:
  - If wb_we=1 and wb_rd!=0: RFWr=1, A3=wb_rd, WD=wb_data.
  - Else if the FIFO is non-empty: RFWr=1, A3=head.rd, WD=head.data. The head pops at the next posedge ("drain").
  - Else RFWr=0, A3=0, WD=0.
- While rst=1, RFWr is forced to 0 regardless of inputs.
- MDU handshake: a transfer occurs when mdu_valid && mdu_ready at a posedge, and the entry is pushed.
  - Results with mdu_rd=0 complete the handshake but are discarded (no push, no pending change).
  - The MDU holds rd/data stable while valid && !ready.
- Push and pop in the same cycle are legal: occupancy is unchanged, and pointers wrap modulo DEPTH.
- Scoreboard: pending[31:1]; pending[0] is hard-wired to 0.
  - mdu_issue with mdu_issue_rd!=0 sets pending[rd].
  - A drain clears pending[head.rd].
  - If a set and a clear hit the same register in the same cycle, the set wins.
  - Issuing to an already-pending register is forbidden. The hazard unit stalls on the busy outputs. If it happens anyway, the bit stays set.
- rsN_busy = pending[q_rsN], combinational; a query for register 0 always returns 0.
- Starvation counter (width ceil(log2(STARVE+1))):
  - Clears on any drain or when the FIFO is empty.
  - Otherwise increments each cycle the head is blocked by a wb write, saturating at STARVE.
  - stall_req is registered: it is 1 in the cycle after the counter reaches STARVE and stays 1 until a drain occurs.
  - The hazard unit responds by forcing wb_we=0 for at least one cycle. Priority never inverts, so wb data is never dropped.

## Timing
- Reset (asynchronous):
  - FIFO empty, so mdu_ready=1.
  - pending=0, so rs1_busy=rs2_busy=0.
  - Counter=0 and stall_req=0.
  - RFWr=0, A3=0, WD=0 when wb_we=0.
- Reset mid-operation discards buffered results and pending bits immediately.
- Minimum MDU result latency: accepted at edge N, written to the RF at edge N+1 if no wb write occurs in that cycle.
- A pushed entry is never drained in the cycle it is pushed; there is no bypass.
- A pending bit clears at the same edge that writes the RF. The busy output stays 1 through the drain cycle and is 0 the cycle after, when the RF read returns the new value.
- Full FIFO: mdu_ready=0. A simultaneous drain does not raise ready until the next cycle, because ready is derived only from registered occupancy.

## Test plan
- Reset: assert rst mid-stream with 2 entries buffered and pending[5]=1 -> immediately mdu_ready=1, rs_busy=0, RFWr=0. After release, no buffered write ever appears.
- Priority: wb_we=1 (rd=3, 0xAAAA) in the same cycle mdu_valid=1 (rd=7, 0x1234), then wb idle -> the cycle-1 write is x3=0xAAAA. The next cycle writes x7=0x1234 and pending[7] clears at that edge.
- Full/backpressure: DEPTH=2 with wb_we=1 continuously, offering 3 MDU results -> 2 are accepted and mdu_ready=0 on the third. After wb stops, the results drain in FIFO order over 2 cycles, and ready returns to 1 one cycle after the first drain.
- Starvation: STARVE=4 with wb_we=1 continuously and one entry buffered -> stall_req=1 five cycles after the push. With wb_we=0 for one cycle the entry drains, and stall_req=0 the following cycle.
- Scoreboard: issue rd=9, query q_rs1=9 -> busy=1. A same-cycle drain of x9 plus a new issue to rd=9 leaves busy=1. Query q_rs2=0 -> busy=0. An MDU result with rd=0 -> accepted, with no RF write and no pending change.
